// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// One radix-2 step per cycle on operand magnitudes, followed by a single
// sign-fixup cycle, giving a fixed latency with no early-out.
//
// state | meaning
// IDLE  | waiting for Start; operands latched on the accepting edge
// RUN   | XLEN shift-add / restoring shift-subtract steps
// FIX   | sign correction, half/quotient/remainder select, Result load
// DONE  | Result valid, Done pulse for one cycle
module execute_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      MulDivOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_reg, b_reg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [CW-1:0]     idx;
  logic [2*XLEN-1:0] mul_step, prod_fix;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   rem_diff, rem_next, quo_next, quo_fix, rem_fix;
  logic              rem_ge, div_zero;
  logic [XLEN-1:0]   result_sel;

  // MULHU, DIVU, REMU are fully unsigned; MULHSU keeps SrcA signed only.
  assign a_signed = (op != 3'b011) && (op != 3'b101) && (op != 3'b111);
  assign b_signed = a_signed && (op != 3'b010);
  assign a_neg    = a_signed & a_reg[XLEN-1];
  assign b_neg    = b_signed & b_reg[XLEN-1];
  assign a_mag    = a_neg ? -a_reg : a_reg;
  assign b_mag    = b_neg ? -b_reg : b_reg;

  // Both iterations walk the operand bits MSB first.
  assign idx      = CW'(XLEN - 1) - cnt;

  assign mul_step = {prod[2*XLEN-2:0], 1'b0}
                  + ({{XLEN{1'b0}}, a_mag} & {(2*XLEN){b_mag[idx]}});

  assign rem_sh   = {rem, a_mag[idx]};
  assign rem_ge   = rem_sh >= {1'b0, b_mag};
  assign rem_diff = rem_sh[XLEN-1:0] - b_mag;
  assign rem_next = rem_ge ? rem_diff : rem_sh[XLEN-1:0];
  assign quo_next = {quo[XLEN-2:0], rem_ge};

  // Divide by zero falls out of the restoring loop as all-ones/dividend
  // magnitude, but the sign fixup would corrupt it, so it is forced here.
  assign div_zero = (b_reg == '0);
  assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
  assign quo_fix  = div_zero ? '1 : ((a_neg ^ b_neg) ? -quo : quo);
  assign rem_fix  = div_zero ? a_reg : (a_neg ? -rem : rem);

  // Select the architectural result for the latched funct3.
  always_comb begin
    result_sel = '0;
    case (op)
      3'b000:                 result_sel = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result_sel = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result_sel = quo_fix;
      default:                result_sel = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; Start is only looked at in IDLE so it never queues.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (cnt == CW'(XLEN - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      op     <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      prod   <= '0;
      quo    <= '0;
      rem    <= '0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            cnt   <= '0;
            op    <= MulDivOp;
            a_reg <= SrcA;
            b_reg <= SrcB;
            prod  <= '0;
            quo   <= '0;
            rem   <= '0;
          end
        end
        RUN: begin
          prod <= mul_step;
          quo  <= quo_next;
          rem  <= rem_next;
          cnt  <= cnt + 1'b1;
        end
        FIX:     Result <= result_sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed and random checks of execute_muldiv against an arithmetic
// reference model of the RV32M multiply/divide rules.
module tb_execute_muldiv;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MulDivOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] Result;

  int errors = 0;
  int checks = 0;

  execute_muldiv #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .Start    (Start),
    .MulDivOp (MulDivOp),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .Busy     (Busy),
    .Done     (Done),
    .Result   (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  function automatic logic [31:0] model(input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      MULHU:  return pu[63:32];
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % longint'({32'd0, b});
        return p[31:0];
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges until Done is seen (bounded); n=40 means it never came.
  task automatic wait_done(output int n, output logic busy_all);
    n = 0;
    busy_all = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
      busy_all &= Busy;
    end while (!Done && n < 40);
  endtask

  // Called one time unit after an edge with the DUT idle; returns in IDLE.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag);
    int   n;
    logic busy_all;
    MulDivOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    Start    = 1'b0;
    SrcA     = $urandom;
    SrcB     = $urandom;
    MulDivOp = 3'($urandom);
    chk({tag, " busy_after_e0"}, 32'(Busy), 32'd1);
    wait_done(n, busy_all);
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " result"}, Result, exp);
    chk({tag, " busy_through_done"}, 32'(busy_all), 32'd1);
    @(posedge clk); #1;
    chk({tag, " idle_after_done"}, {30'd0, Busy, Done}, 32'd0);
    chk({tag, " result_held"}, Result, exp);
  endtask

  initial begin
    int          n, m, seen;
    logic        busy_all;
    logic [2:0]  op;
    logic [31:0] a, b, r1, r2;

    reset = 1'b1; Start = 1'b0; MulDivOp = 3'd0; SrcA = '0; SrcB = '0;
    #2;
    chk("reset_state", {Result[29:0], Busy, Done}, 32'd0);
    chk("reset_result", Result, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    do_op(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3");
    do_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones");
    do_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ones");
    do_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    do_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2");
    do_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2");
    do_op(DIVU,   32'd100,       32'd7,         32'd14,        "divu_100_7");
    do_op(REMU,   32'd100,       32'd7,         32'd2,         "remu_100_7");
    do_op(DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, "divu_by0");
    do_op(REMU,   32'd5,         32'd0,         32'd5,         "remu_by0");
    do_op(DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_by0");
    do_op(REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, "rem_by0");
    do_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    do_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf");

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 255);
        default: ;
      endcase
      do_op(op, a, b, model(op, a, b), "random");
    end

    // Start pulsed across E10 with different operands must not disturb
    // the operation in flight nor start another one afterwards.
    r1 = model(MUL, 32'd12345, 32'd678);
    MulDivOp = MUL; SrcA = 32'd12345; SrcB = 32'd678; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    MulDivOp = DIVU; SrcA = 32'd999; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    wait_done(n, busy_all);
    chk("pulse_e10 latency", 32'(n), 32'd23);
    chk("pulse_e10 result", Result, r1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pulse_e10 not_queued", 32'(Busy), 32'd0);

    // Start held high through RUN/FIX/DONE: only the first IDLE edge takes
    // it, leaving 34 cycles strictly between the two Done pulses.
    r1 = model(MULH, 32'hDEAD_BEEF, 32'h1234_5678);
    r2 = model(REM,  32'hF000_0001, 32'd77);
    MulDivOp = MULH; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; Start = 1'b1;
    @(posedge clk); #1;
    MulDivOp = REM; SrcA = 32'hF000_0001; SrcB = 32'd77;
    wait_done(n, busy_all);
    chk("held first latency", 32'(n), 32'd33);
    chk("held first result", Result, r1);
    m = 0;
    do begin
      @(posedge clk); #1;
      m++;
    end while (!Done && m < 60);
    Start = 1'b0;
    chk("held done_spacing", 32'(m), 32'd35);
    chk("held second result", Result, r2);
    @(posedge clk); #1;

    // Reset in the middle of RUN, between edges.
    MulDivOp = MUL; SrcA = 32'h0000_1234; SrcB = 32'h0000_0010; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrun_reset busy", 32'(Busy), 32'd0);
    chk("midrun_reset done", 32'(Done), 32'd0);
    chk("midrun_reset result", Result, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (Done || Busy) seen++;
    end
    chk("after_reset no_done", 32'(seen), 32'd0);
    do_op(MUL, 32'd3, 32'd4, 32'd12, "post_reset_mul");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
